// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the SDRAM memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_BURST = 2'd2
    } arb_state_t;

    localparam int unsigned BURST_BEATS = 4;
    localparam int unsigned ADDR_W      = 22;
    localparam int unsigned DATA_W      = 16;
    // Widest supported port count and the index width that covers it.
    localparam int unsigned PORT_MAX    = 8;
    localparam int unsigned IDX_W       = 3;

    // Index of the set bit in a one-hot vector; 0 when the vector is empty.
    function automatic logic [IDX_W-1:0] onehot_to_index(input logic [PORT_MAX-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < PORT_MAX; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// mem_interface: one command/data channel between a memory master and the SDRAM side.
interface mem_interface;
    import mem_arb_pkg::*;

    logic [DATA_W-1:0] data_write;
    logic [ADDR_W-1:0] address;
    logic              request;
    logic              write_enable;
    logic              last4;
    logic [DATA_W-1:0] data_read;
    logic              ready;

    // Issues commands, receives read data and ready.
    modport master (
        output data_write, address, request, write_enable, last4,
        input  data_read, ready
    );

    // Accepts commands, returns read data and ready.
    modport slave (
        input  data_write, address, request, write_enable, last4,
        output data_read, ready
    );

endinterface

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping, skipping excluded ports.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned PORT_COUNT = 2
) (
    input  logic [PORT_COUNT-1:0] req,
    input  logic [IDX_W-1:0]      ptr,
    input  logic [PORT_COUNT-1:0] exclude_mask,
    output logic [PORT_COUNT-1:0] pick,
    output logic                  valid
);

    logic [PORT_COUNT-1:0] cand;

    assign cand = req & ~exclude_mask;

    // Scan ptr+1, ptr+2, ... ptr (last) and take the first candidate.
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        for (int unsigned off = 1; off <= PORT_COUNT; off++) begin
            for (int unsigned i = 0; i < PORT_COUNT; i++) begin
                if (!valid && cand[i] && (i == (32'(ptr) + off) % PORT_COUNT)) begin
                    pick[i] = 1'b1;
                    valid   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one SDRAM controller port between PORT_COUNT requesters.
// Round robin with 4-beat burst locking, per-grant hold quota and a sticky switch request.
// Optional MEM_ARB_PRIO0_EN: port 0 wins every arbitration/boundary it requests at.
module memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned PORT_COUNT = 2,
    parameter int unsigned MAX_HOLD   = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  switch,
    mem_interface.master          resource,
    mem_interface.slave           port_list [PORT_COUNT],
    output logic [PORT_COUNT-1:0] grant
);

    localparam logic [1:0]  StIdle  = ARB_IDLE;
    localparam logic [1:0]  StGrant = ARB_GRANT;
    localparam logic [1:0]  StBurst = ARB_BURST;
    localparam int unsigned HOLD_W  = $clog2(MAX_HOLD + 1);
    localparam int unsigned BEAT_W  = $clog2(BURST_BEATS);

    logic [1:0]            state_q, state_d;
    logic [PORT_COUNT-1:0] grant_q, grant_d, last_grant_q;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [IDX_W-1:0]      rr_q, rr_d;
    logic                  sw_q, sw_d;
    // Set until the first grant after reset so that port 0 is served first.
    logic                  fresh_q, fresh_d;
    logic                  boundary;

    logic [PORT_COUNT-1:0] req, we_v, last4_v;
    logic [ADDR_W-1:0]     addr_v  [PORT_COUNT];
    logic [DATA_W-1:0]     wdata_v [PORT_COUNT];

    for (genvar g = 0; g < PORT_COUNT; g++) begin : g_port
        assign req[g]     = port_list[g].request;
        assign we_v[g]    = port_list[g].write_enable;
        assign last4_v[g] = port_list[g].last4;
        assign addr_v[g]  = port_list[g].address;
        assign wdata_v[g] = port_list[g].data_write;
        assign port_list[g].ready     = reset_n & grant_q[g] & resource.ready & req[g];
        assign port_list[g].data_read = resource.data_read;
    end

    // Arbitration: optional port-0 override on top of the round-robin picker.
    logic                  prio0, pick_valid, arb_valid;
    logic [PORT_COUNT-1:0] rr_req, pick, arb_grant, excl;
    logic [IDX_W-1:0]      pick_ptr;

`ifdef MEM_ARB_PRIO0_EN
    assign prio0  = req[0];
    assign rr_req = req & ~PORT_COUNT'(1);
`else
    assign prio0  = 1'b0;
    assign rr_req = req;
`endif

    assign excl      = (state_q == StIdle) ? '0 : grant_q;
    assign pick_ptr  = fresh_q ? IDX_W'(PORT_COUNT - 1) : rr_q;
    assign arb_valid = prio0 | pick_valid;
    assign arb_grant = prio0 ? PORT_COUNT'(1) : pick;

    mem_arb_rr_pick #(
        .PORT_COUNT (PORT_COUNT)
    ) u_pick (
        .req          (rr_req),
        .ptr          (pick_ptr),
        .exclude_mask (excl),
        .pick         (pick),
        .valid        (pick_valid)
    );

    logic own_req, own_last4;
    assign own_req   = |(grant_q & req);
    assign own_last4 = |(grant_q & last4_v);

    // Forward the owner's command; write data follows the previous cycle's owner.
    logic [ADDR_W-1:0] res_addr;
    logic [DATA_W-1:0] res_wd;
    logic              res_req, res_we, res_l4;

    always_comb begin
        res_addr = '0;
        res_wd   = '0;
        res_req  = 1'b0;
        res_we   = 1'b0;
        res_l4   = 1'b0;
        for (int unsigned i = 0; i < PORT_COUNT; i++) begin
            if (grant_q[i]) begin
                res_addr = res_addr | addr_v[i];
                res_req  = res_req | req[i];
                res_we   = res_we | we_v[i];
                res_l4   = res_l4 | last4_v[i];
            end
            if (last_grant_q[i]) res_wd = res_wd | wdata_v[i];
        end
    end

    assign resource.address      = reset_n ? res_addr : '0;
    assign resource.data_write   = reset_n ? res_wd : '0;
    assign resource.request      = reset_n & res_req;
    assign resource.write_enable = reset_n & res_we;
    assign resource.last4        = reset_n & res_l4;
    assign grant                 = reset_n ? grant_q : '0;

    // Next-state: FSM transitions, transfer boundaries and rotation decision.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        hold_d   = hold_q;
        beat_d   = beat_q;
        rr_d     = rr_q;
        fresh_d  = fresh_q;
        sw_d     = sw_q | switch;
        boundary = 1'b0;
        case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (!own_req) begin
                    // Owner released: re-arbitrate now, new owner visible next cycle.
                    grant_d = arb_valid ? arb_grant : '0;
                    if (!arb_valid) state_d = StIdle;
                end else if (resource.ready) begin
                    if (own_last4) begin
                        state_d = StBurst;
                        beat_d  = BEAT_W'(1);
                    end else begin
                        boundary = 1'b1;
                    end
                end
            end
            StBurst: begin
                if (resource.ready) begin
                    if (beat_q == BEAT_W'(BURST_BEATS - 1)) begin
                        state_d  = StGrant;
                        beat_d   = '0;
                        boundary = 1'b1;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
        if (boundary) begin
            hold_d = (hold_q < HOLD_W'(MAX_HOLD)) ? hold_q + HOLD_W'(1) : hold_q;
            if (arb_valid && (prio0 ? !grant_q[0] : (sw_d || hold_d == HOLD_W'(MAX_HOLD)))) begin
                grant_d = arb_grant;
            end
        end
        if (grant_d != grant_q) begin
            hold_d = '0;
            sw_d   = 1'b0;
            if (|grant_d) begin
                rr_d    = onehot_to_index(PORT_MAX'(grant_d));
                fresh_d = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= '0;
            hold_q       <= '0;
            beat_q       <= '0;
            rr_q         <= '0;
            sw_q         <= 1'b0;
            fresh_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= grant_q;
            hold_q       <= hold_d;
            beat_q       <= beat_d;
            rr_q         <= rr_d;
            sw_q         <= sw_d;
            fresh_q      <= fresh_d;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized traffic
// compared every cycle against an owner-index reference model.
module tb_memory_arbiter;
    import mem_arb_pkg::*;

    localparam int N  = 3;
    localparam int MH = 2;

    logic clock = 1'b0;
    logic reset_n, switch;
    logic [N-1:0] req, we, l4;
    logic [ADDR_W-1:0] addr [N];
    logic [DATA_W-1:0] wd   [N];
    logic c_ready;
    logic [DATA_W-1:0] c_rdata;
    logic [N-1:0] grant, rdy;
    logic [DATA_W-1:0] rdat [N];

    int checks = 0;
    int failures = 0;

    // Reference model: owner/last are port indices, -1 means none.
    int m_owner, m_last, m_hold, m_beats, m_rr;
    bit m_burst, m_sw, m_fresh;

    mem_interface res_if ();
    mem_interface pif [N] ();

    for (genvar g = 0; g < N; g++) begin : g_port
        assign pif[g].request      = req[g];
        assign pif[g].write_enable = we[g];
        assign pif[g].last4        = l4[g];
        assign pif[g].address      = addr[g];
        assign pif[g].data_write   = wd[g];
        assign rdy[g]              = pif[g].ready;
        assign rdat[g]             = pif[g].data_read;
    end
    assign res_if.ready     = c_ready;
    assign res_if.data_read = c_rdata;

    memory_arbiter #(
        .PORT_COUNT (N),
        .MAX_HOLD   (MH)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .switch    (switch),
        .resource  (res_if),
        .port_list (pif),
        .grant     (grant)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner among requesters other than excl, scanning from the port after the last owner.
    function automatic int arb(input int excl);
        int start;
        start = m_fresh ? 0 : m_rr + 1;
`ifdef MEM_ARB_PRIO0_EN
        if (req[0] && excl != 0) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
`ifdef MEM_ARB_PRIO0_EN
            if (i == 0) continue;
`endif
            if (req[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = -1; m_hold = 0; m_beats = 0; m_rr = 0;
        m_burst = 0; m_sw = 0; m_fresh = 1;
    endtask

    // Compare all outputs against the model at the falling edge.
    task automatic sample();
        logic [N-1:0] e_grant, e_rdy;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd;
        logic e_req, e_we, e_l4;
        @(negedge clock);
        e_grant = '0; e_rdy = '0; e_addr = '0; e_wd = '0;
        e_req = 1'b0; e_we = 1'b0; e_l4 = 1'b0;
        if (reset_n) begin
            if (m_owner >= 0) begin
                e_grant[m_owner] = 1'b1;
                e_addr = addr[m_owner];
                e_req  = req[m_owner];
                e_we   = we[m_owner];
                e_l4   = l4[m_owner];
                e_rdy[m_owner] = c_ready & req[m_owner];
            end
            if (m_last >= 0) e_wd = wd[m_last];
        end
        chk("m_grant", grant, e_grant);
        chk("m_request", res_if.request, e_req);
        chk("m_address", res_if.address, e_addr);
        chk("m_write_enable", res_if.write_enable, e_we);
        chk("m_last4", res_if.last4, e_l4);
        chk("m_data_write", res_if.data_write, e_wd);
        chk("m_ready", rdy, e_rdy);
        for (int i = 0; i < N; i++) chk("m_data_read", rdat[i], c_rdata);
    endtask

    // Advance the model across the rising edge using the inputs held during the cycle.
    task automatic adv();
        int nxt, w;
        bit bnd;
        @(posedge clock);
        if (!reset_n) begin
            model_reset();
        end else begin
            nxt = m_owner;
            bnd = 0;
            m_sw = m_sw | switch;
            if (m_owner < 0) begin
                nxt = arb(-1);
            end else if (m_burst) begin
                if (c_ready) begin
                    m_beats++;
                    if (m_beats == BURST_BEATS) begin
                        m_burst = 0;
                        bnd = 1;
                    end
                end
            end else if (!req[m_owner]) begin
                nxt = arb(m_owner);
            end else if (c_ready) begin
                if (l4[m_owner]) begin
                    m_burst = 1;
                    m_beats = 1;
                end else begin
                    bnd = 1;
                end
            end
            if (bnd) begin
                if (m_hold < MH) m_hold++;
                w = arb(m_owner);
`ifdef MEM_ARB_PRIO0_EN
                if (req[0]) begin
                    if (m_owner != 0) nxt = 0;
                end else if (w >= 0 && (m_sw || m_hold == MH)) nxt = w;
`else
                if (w >= 0 && (m_sw || m_hold == MH)) nxt = w;
`endif
            end
            if (nxt != m_owner) begin
                m_hold = 0;
                m_sw = 0;
                if (nxt >= 0) begin
                    m_rr = nxt;
                    m_fresh = 0;
                end
            end
            m_last = m_owner;
            m_owner = nxt;
        end
        #1;
    endtask

    task automatic step();
        sample();
        adv();
    endtask

    // Reset for one cycle, release, and check the idle cycle before the first grant.
    task automatic restart();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        sample();
        chk("release_idle", grant, 3'b000);
        adv();
    endtask

    initial begin
        logic [N-1:0] exp_tbl [7];
        int pulses [N];

        model_reset();
        reset_n = 1'b0; switch = 1'b0; c_ready = 1'b1; c_rdata = 16'h5A5A;
        req = 3'b111; we = '0; l4 = '0;
        for (int i = 0; i < N; i++) begin
            addr[i] = ADDR_W'(22'h1000 * (i + 1));
            wd[i]   = DATA_W'(16'h1111 * (i + 1));
        end

        // Reset held with every port requesting.
        step();
        sample();
        chk("rst_grant", grant, 3'b000);
        chk("rst_request", res_if.request, 1'b0);
        chk("rst_ready", rdy, 3'b000);
        adv();

        // Round robin, MAX_HOLD=2, single reads acknowledged every cycle.
        reset_n = 1'b1;
        sample();
        chk("rr_release_idle", grant, 3'b000);
        adv();
        exp_tbl[0] = 3'b001; exp_tbl[1] = 3'b001; exp_tbl[2] = 3'b010; exp_tbl[3] = 3'b010;
        exp_tbl[4] = 3'b100; exp_tbl[5] = 3'b100; exp_tbl[6] = 3'b001;
        for (int i = 0; i < N; i++) pulses[i] = 0;
        for (int k = 0; k < 7; k++) begin
            sample();
            chk("rr_grant", grant, exp_tbl[k]);
            if (k < 6) for (int i = 0; i < N; i++) pulses[i] += int'(rdy[i]);
            adv();
        end
        for (int i = 0; i < N; i++) chk("rr_pulses", pulses[i], 2);

        // Burst lock: switch on beat 2 must wait for the burst to finish.
        req = 3'b011; l4 = 3'b001;
        restart();
        exp_tbl[0] = 3'b001; exp_tbl[1] = 3'b001; exp_tbl[2] = 3'b001; exp_tbl[3] = 3'b001;
        exp_tbl[4] = 3'b010;
        for (int k = 0; k < 5; k++) begin
            switch = (k == 1);
            sample();
            chk("burst_grant", grant, exp_tbl[k]);
            adv();
        end
        switch = 1'b0; l4 = '0;

        // Write lag: data follows the command by one cycle.
        req = 3'b010; we = 3'b010; c_ready = 1'b0;
        addr[1] = 22'h00123; wd[0] = 16'h1111; wd[1] = 16'hBEEF; wd[2] = 16'h2222;
        restart();
        sample();
        chk("wr_grant", grant, 3'b010);
        chk("wr_address", res_if.address, 22'h00123);
        chk("wr_we", res_if.write_enable, 1'b1);
        chk("wr_data_early", res_if.data_write, 16'h0000);
        adv();
        sample();
        chk("wr_data_lag", res_if.data_write, 16'hBEEF);
        adv();
        we = '0;

        // Owner drop: port 0 releases while ready is high; port 1 takes over.
        req = 3'b011; c_ready = 1'b1;
        restart();
        req = 3'b010;
        sample();
        chk("drop_grant_hold", grant, 3'b001);
        chk("drop_ready0", rdy, 3'b000);
        adv();
        sample();
        chk("drop_grant_new", grant, 3'b010);
        chk("drop_ready1", rdy, 3'b010);
        adv();

`ifdef MEM_ARB_PRIO0_EN
        // Port 0 joins mid-stream and takes the next boundary.
        req = 3'b110;
        restart();
        req = 3'b111;
        sample();
        chk("prio_stream", grant, 3'b010);
        adv();
        sample();
        chk("prio_grant", grant, 3'b001);
        adv();
`endif

        // Randomized traffic, including occasional mid-burst resets.
        for (int c = 0; c < 800; c++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
                l4[i]   = ($urandom_range(0, 4) == 0);
                we[i]   = 1'($urandom);
                addr[i] = ADDR_W'($urandom);
                wd[i]   = DATA_W'($urandom);
            end
            switch  = ($urandom_range(0, 7) == 0);
            c_ready = 1'($urandom);
            c_rdata = DATA_W'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
